// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier controller.
// Used by booth_cnt and booth_ctrl.
package booth_pkg;

  localparam int BOOTH_ITER = 8;
  localparam int CNT_W      = 3;

  // The final iteration index, at which SHIFT leaves the loop instead of wrapping.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOOTH_ITER - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_M = 4'd1,
    LOAD_Q = 4'd2,
    CHECK  = 4'd3,
    ADD    = 4'd4,
    SUB    = 4'd5,
    SHIFT  = 4'd6,
    OUT_A  = 4'd7,
    OUT_Q  = 4'd8,
    DONE   = 4'd9
  } state_e;

endpackage

// File: rtl/booth_cnt.sv
// Iteration counter for the Booth controller: clear, increment and a last flag.
// The count value is only brought out when BOOTH_CTRL_DBG_EN is defined.
module booth_cnt
  import booth_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr_i,
  input  logic             inc_i,
`ifdef BOOTH_CTRL_DBG_EN
  output logic [CNT_W-1:0] cnt_o,
`endif
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_LAST);

`ifdef BOOTH_CTRL_DBG_EN
  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/booth_ctrl.sv
// Moore control FSM sequencing a radix-2 Booth multiplier datapath (8 iterations).
// Defining BOOTH_CTRL_DBG_EN adds the dbg_state and dbg_cnt observation outputs.
module booth_ctrl
  import booth_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             q0,
  input  logic             q_m1,
  output logic             c0,
  output logic             c1,
  output logic             c2,
  output logic             c3,
  output logic             c4,
  output logic             c5,
  output logic             c6,
  output logic             c7,
  output logic             busy,
  output logic             done
`ifdef BOOTH_CTRL_DBG_EN
  ,
  output logic [3:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
`endif
);

  state_e state_q, state_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;

`ifdef BOOTH_CTRL_DBG_EN
  logic [CNT_W-1:0] cnt;
`endif

  assign cnt_clr = (state_q == LOAD_Q);
  assign cnt_inc = (state_q == SHIFT) && !cnt_last;

  booth_cnt u_cnt (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
`ifdef BOOTH_CTRL_DBG_EN
    .cnt_o  (cnt),
`endif
    .last_o (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Booth recoding of {Q0,Q-1}: 10 subtracts M, 01 adds M, 00/11 only shift.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_M;
      LOAD_M:  state_d = LOAD_Q;
      LOAD_Q:  state_d = CHECK;
      CHECK: begin
        case ({q0, q_m1})
          2'b10:   state_d = SUB;
          2'b01:   state_d = ADD;
          default: state_d = SHIFT;
        endcase
      end
      ADD:     state_d = SHIFT;
      SUB:     state_d = SHIFT;
      SHIFT:   state_d = cnt_last ? OUT_A : CHECK;
      OUT_A:   state_d = OUT_Q;
      OUT_Q:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on the state register alone, so reset clears them without a clock.
  always_comb begin
    c0   = 1'b0;
    c1   = 1'b0;
    c2   = 1'b0;
    c3   = 1'b0;
    c4   = 1'b0;
    c5   = 1'b0;
    c6   = 1'b0;
    c7   = 1'b0;
    done = 1'b0;
    busy = (state_q != IDLE);
    case (state_q)
      LOAD_M: c7 = 1'b1;
      LOAD_Q: begin
        c0 = 1'b1;
        c1 = 1'b1;
      end
      ADD:    c2 = 1'b1;
      SUB: begin
        c2 = 1'b1;
        c3 = 1'b1;
      end
      SHIFT:  c4 = 1'b1;
      OUT_A:  c5 = 1'b1;
      OUT_Q:  c6 = 1'b1;
      DONE:   done = 1'b1;
      default: ;
    endcase
  end

`ifdef BOOTH_CTRL_DBG_EN
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt;
`endif

endmodule

// File: tb/tb_booth_ctrl.sv
// Self-checking bench for booth_ctrl: a behavioural Booth datapath closes the loop and
// products, ADD/SUB counts and latency are compared against an arithmetic reference.
module tb_booth_ctrl;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic start = 1'b0;
  logic q0, q_m1;
  logic c0, c1, c2, c3, c4, c5, c6, c7, busy, done;

  logic [7:0] mval = '0;
  logic [7:0] qval = '0;
  logic [7:0] dpA = '0;
  logic [7:0] dpQ = '0;
  logic [7:0] dpM = '0;
  logic       dpQm1 = 1'b0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  booth_ctrl dut (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start),
    .q0    (q0),
    .q_m1  (q_m1),
    .c0    (c0),
    .c1    (c1),
    .c2    (c2),
    .c3    (c3),
    .c4    (c4),
    .c5    (c5),
    .c6    (c6),
    .c7    (c7),
    .busy  (busy),
    .done  (done)
  );

  assign q0   = dpQ[0];
  assign q_m1 = dpQm1;

  // Behavioural datapath obeying the control lines.
  always @(posedge clk) begin
    if (c7) dpM <= mval;
    if (c1) dpQ <= qval;
    if (c0) begin
      dpA   <= '0;
      dpQm1 <= 1'b0;
    end
    if (c2) dpA <= c3 ? dpA - dpM : dpA + dpM;
    if (c4) {dpA, dpQ, dpQm1} <= {dpA[7], dpA, dpQ};
  end

  // Reference: signed product, and ADD/SUB counts from the Booth recoding of Q.
  function automatic void refModel(input logic [7:0] m, input logic [7:0] q,
                                    output logic [15:0] p, output int adds, output int subs);
    int  full;
    logic prev;
    full = $signed(m) * $signed(q);
    p = full[15:0];
    adds = 0;
    subs = 0;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (q[i] && !prev) subs++;
      if (!q[i] && prev) adds++;
      prev = q[i];
    end
  endfunction

  // Runs one product; doneAt is the number of edges after the start-sampling edge.
  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] q, input bit jitter,
                               output int doneAt, output int nAdd, output int nSub,
                               output int nShift, output int nOutA, output int nOutQ,
                               output logic [15:0] prod, output bit protoOk);
    bit seen;
    seen = 0;
    doneAt = -1;
    nAdd = 0; nSub = 0; nShift = 0; nOutA = 0; nOutQ = 0;
    prod = '0;
    protoOk = 1;
    @(negedge clk);
    mval = m;
    qval = q;
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 60 && !seen; j++) begin
      @(negedge clk);
      if (c2 && c3) nSub++;
      if (c2 && !c3) nAdd++;
      if (c3 && !c2) protoOk = 0;
      if (c5 && c6) protoOk = 0;
      if (!busy) protoOk = 0;
      if (c4) nShift++;
      if (c5) begin nOutA++; prod[15:8] = dpA; end
      if (c6) begin nOutQ++; prod[7:0] = dpQ; end
      start = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
      if (done) begin
        seen = 1;
        doneAt = j;
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({c0, c1, c2, c3, c4, c5, c6, c7, busy, done} !== 10'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %b expected 0", {c0, c1, c2, c3, c4, c5, c6, c7, busy, done});
    end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, c7, done} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL idle_hold: got busy/c7/done=%b expected 000", {busy, c7, done});
    end
  endtask

  task automatic test_directed();
    logic [7:0]  mv [3] = '{8'h03, 8'h07, 8'h00};
    logic [7:0]  qv [3] = '{8'hFE, 8'h55, 8'h00};
    logic [15:0] pv [3] = '{16'hFFFA, 16'h0253, 16'h0000};
    int          av [3] = '{0, 4, 0};
    int          sv [3] = '{1, 4, 0};
    int doneAt, nAdd, nSub, nShift, nOutA, nOutQ;
    logic [15:0] prod;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mv[i], qv[i], 1'b0, doneAt, nAdd, nSub, nShift, nOutA, nOutQ, prod, ok);
      checks++;
      if (doneAt !== 20 + av[i] + sv[i]) begin
        fails++;
        $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, doneAt, 20 + av[i] + sv[i]);
      end
      checks++;
      if (nAdd !== av[i] || nSub !== sv[i]) begin
        fails++;
        $display("[TB] FAIL dir%0d_addsub: got add=%0d sub=%0d expected add=%0d sub=%0d", i, nAdd, nSub, av[i], sv[i]);
      end
      checks++;
      if (prod !== pv[i]) begin
        fails++;
        $display("[TB] FAIL dir%0d_product: got %h expected %h", i, prod, pv[i]);
      end
      checks++;
      if (nShift !== 8 || nOutA !== 1 || nOutQ !== 1) begin
        fails++;
        $display("[TB] FAIL dir%0d_phases: got shift=%0d outA=%0d outQ=%0d expected 8/1/1", i, nShift, nOutA, nOutQ);
      end
      checks++;
      if (!ok) begin
        fails++;
        $display("[TB] FAIL dir%0d_protocol: got 0 expected 1", i);
      end
    end
  endtask

  task automatic test_random(input int count, input bit jitter);
    int doneAt, nAdd, nSub, nShift, nOutA, nOutQ, eAdd, eSub;
    logic [15:0] prod, eProd;
    logic [7:0] m, q;
    bit ok;
    for (int i = 0; i < count; i++) begin
      m = 8'($urandom);
      q = 8'($urandom);
      refModel(m, q, eProd, eAdd, eSub);
      applyStimulus(m, q, jitter, doneAt, nAdd, nSub, nShift, nOutA, nOutQ, prod, ok);
      checks++;
      if (doneAt !== 20 + eAdd + eSub) begin
        fails++;
        $display("[TB] FAIL rnd_latency m=%h q=%h: got %0d expected %0d", m, q, doneAt, 20 + eAdd + eSub);
      end
      checks++;
      if (nAdd !== eAdd || nSub !== eSub) begin
        fails++;
        $display("[TB] FAIL rnd_addsub m=%h q=%h: got add=%0d sub=%0d expected add=%0d sub=%0d", m, q, nAdd, nSub, eAdd, eSub);
      end
      checks++;
      if (prod !== eProd) begin
        fails++;
        $display("[TB] FAIL rnd_product m=%h q=%h: got %h expected %h", m, q, prod, eProd);
      end
      checks++;
      if (nShift !== 8 || nOutA !== 1 || nOutQ !== 1) begin
        fails++;
        $display("[TB] FAIL rnd_phases m=%h q=%h: got shift=%0d outA=%0d outQ=%0d expected 8/1/1", m, q, nShift, nOutA, nOutQ);
      end
      checks++;
      if (!ok) begin
        fails++;
        $display("[TB] FAIL rnd_protocol m=%h q=%h jitter=%0d: got 0 expected 1", m, q, jitter);
      end
    end
  endtask

  task automatic test_reset_midop();
    int shiftsBefore, doneAt, nAdd, nSub, nShift, nOutA, nOutQ, eAdd, eSub;
    logic [15:0] prod, eProd;
    bit found, ok;
    found = 0;
    shiftsBefore = 0;
    @(negedge clk);
    mval = 8'h5A;
    qval = 8'h08;
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 40 && !found; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (c2 && c3) found = 1;
      else if (c4) shiftsBefore++;
    end
    checks++;
    if (!found || shiftsBefore !== 3) begin
      fails++;
      $display("[TB] FAIL midop_sub_iter: got found=%0d shifts=%0d expected 1/3", found, shiftsBefore);
    end
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({c0, c1, c2, c3, c4, c5, c6, c7, busy, done} !== 10'b0) begin
      fails++;
      $display("[TB] FAIL midop_async_clear: got %b expected 0", {c0, c1, c2, c3, c4, c5, c6, c7, busy, done});
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midop_idle: got busy=%b expected 0", busy);
    end
    refModel(8'h5A, 8'h08, eProd, eAdd, eSub);
    applyStimulus(8'h5A, 8'h08, 1'b0, doneAt, nAdd, nSub, nShift, nOutA, nOutQ, prod, ok);
    checks++;
    if (prod !== eProd || doneAt !== 20 + eAdd + eSub) begin
      fails++;
      $display("[TB] FAIL midop_restart: got prod=%h lat=%0d expected prod=%h lat=%0d", prod, doneAt, eProd, 20 + eAdd + eSub);
    end
  endtask

  task automatic test_back_to_back();
    int doneQ[$];
    int loadQ[$];
    logic [15:0] prodQ[$];
    logic [7:0] aTmp, m, q;
    logic [15:0] eProd;
    int eAdd, eSub;
    aTmp = '0;
    m = 8'($urandom);
    q = 8'($urandom);
    refModel(m, q, eProd, eAdd, eSub);
    @(negedge clk);
    mval = m;
    qval = q;
    start = 1'b1;
    for (int j = 0; j < 100 && doneQ.size() < 2; j++) begin
      @(negedge clk);
      if (c7) loadQ.push_back(j);
      if (c5) aTmp = dpA;
      if (c6) prodQ.push_back({aTmp, dpQ});
      if (done) doneQ.push_back(j);
    end
    start = 1'b0;
    checks++;
    if (doneQ.size() != 2 || loadQ.size() != 2 || prodQ.size() != 2) begin
      fails++;
      $display("[TB] FAIL b2b_events: got done=%0d load=%0d out=%0d expected 2/2/2", doneQ.size(), loadQ.size(), prodQ.size());
    end else begin
      checks++;
      if (loadQ[1] - doneQ[0] != 2) begin
        fails++;
        $display("[TB] FAIL b2b_gap: got %0d cycles DONE->LOAD_M expected 2", loadQ[1] - doneQ[0]);
      end
      checks++;
      if (doneQ[1] - loadQ[1] != 20 + eAdd + eSub) begin
        fails++;
        $display("[TB] FAIL b2b_latency: got %0d expected %0d", doneQ[1] - loadQ[1], 20 + eAdd + eSub);
      end
      checks++;
      if (prodQ[0] !== eProd || prodQ[1] !== eProd) begin
        fails++;
        $display("[TB] FAIL b2b_product: got %h/%h expected %h", prodQ[0], prodQ[1], eProd);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(6, 1'b0);
    test_random(2, 1'b1);
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/booth_ctrl.md
BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 The block SHALL have these ports, with the clock and reset listed first:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- start  in  1  request a new multiplication; sampled only in IDLE.
- q0  in  1  current LSB of the Q register.
- q_m1  in  1  current Q(-1) bit of the datapath.
- c0  out  1  clear A and Q(-1).
- c1  out  1  load Q from the input bus.
- c2  out  1  write the adder sum into A.
- c3  out  1  adder mode (1 = A-M, 0 = A+M).
- c4  out  1  arithmetic shift right of A:Q:Q(-1).
- c5  out  1  drive A onto obus.
- c6  out  1  drive Q onto obus.
- c7  out  1  load M from the input bus.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse marking the end of a product.

Function
REQ-002 The block SHALL be a Moore FSM with states IDLE, LOAD_M, LOAD_Q, CHECK, ADD, SUB, SHIFT, OUT_A, OUT_Q and DONE; all outputs SHALL decode from the state register only.
REQ-003 In IDLE, start=1 SHALL cause a transition to LOAD_M; start=0 SHALL keep the FSM in IDLE.
REQ-004 LOAD_M SHALL assert c7 and go to LOAD_Q.
REQ-005 LOAD_Q SHALL assert c0 and c1 together, clear the iteration counter to 0, and go to CHECK.
REQ-006 CHECK SHALL assert no outputs and branch on {q0,q_m1}: 2'b10 to SUB, 2'b01 to ADD, 2'b00 or 2'b11 to SHIFT.
REQ-007 ADD SHALL assert c2 with c3=0 and go to SHIFT.
REQ-008 SUB SHALL assert c2 and c3 and go to SHIFT.
REQ-009 SHIFT SHALL assert c4; with the counter at 7 it SHALL go to OUT_A, otherwise it SHALL increment the counter and go to CHECK.
REQ-010 OUT_A SHALL assert c5 and go to OUT_Q; OUT_Q SHALL assert c6 and go to DONE.
REQ-011 DONE SHALL assert done for exactly one cycle and go to IDLE.
REQ-012 c3 SHALL be 0 in every state except SUB, and at most one of c5 and c6 SHALL be high in any cycle.
REQ-013 Exactly 8 SHIFT states SHALL occur per product; the counter is 3 bits, and its wrap from 7 to 0 SHALL never be reached.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 Latency: if start is sampled at edge k, done SHALL be high in the cycle after edge k+20+N, where N is the number of ADD/SUB states visited (0..8).
REQ-016 When DONE is followed immediately by IDLE with start=1, a new product SHALL begin with no extra idle cycle beyond that IDLE.

Reset
REQ-017 rst_b=0 SHALL immediately force IDLE, a zero counter, and c0..c7, busy and done all 0, including mid-operation.
REQ-018 After rst_b deasserts, the first rising edge SHALL evaluate IDLE normally.

Configuration
REQ-019 When BOOTH_CTRL_DBG_EN is defined, the block SHALL add outputs dbg_state (4 bits, state encoding) and dbg_cnt (3 bits, iteration counter).
REQ-020 When BOOTH_CTRL_DBG_EN is undefined, those outputs and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 The package booth_pkg SHALL hold the state enumeration, the constant BOOTH_ITER=8, and the counter width constant CNT_W=3.
REQ-022 The iteration counter SHALL be a sub-module booth_cnt with clear, increment and a last flag (count==7).

Verification
REQ-023 With a behavioural datapath, M=3 and Q=8'hFE, start at edge k: exactly one SUB and no ADD occur, done is high after edge k+21, and the product read via c5/c6 is 16'hFFFA.
REQ-024 M=8'h07, Q=8'h55: the sequence alternates SUB and ADD for all 8 iterations, done is high after edge k+28, and the product is 16'h0253.
REQ-025 M=0, Q=0: no ADD/SUB occurs, done is high after edge k+20, and OUT_A and OUT_Q each last exactly one cycle.
REQ-026 Pulse start repeatedly during an operation: there is no effect on state or timing, and busy stays 1 until DONE.
REQ-027 Drop rst_b during SUB of iteration 4: all outputs go to 0 without waiting for a clock edge, the FSM is in IDLE, and a fresh start then yields the correct product.
REQ-028 Hold start=1 continuously: back-to-back products run with exactly one IDLE cycle between DONE and LOAD_M.
